// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the ID-stage scoreboard hazard unit.
//   LAT_*      : producer latency codes presented on id_lat by the decoder.
//   NUM_REGS   : number of tracked GPR slots for the default index width.
//   READY_*    : countdown value at or below which a consumer may proceed.
package hazard_pkg;

  // Extra cycles before a producer's result can be forwarded into EXE.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_SC   = 1;

  // Default register index width of the MIPS register file.
  localparam int unsigned DEF_REG_W = 5;
  localparam int unsigned NUM_REGS  = 2 ** DEF_REG_W;

  // An EXE consumer can take the value off the forwarding path one cycle
  // earlier than a branch that compares operands inside ID.
  localparam int unsigned READY_EXE = 1;
  localparam int unsigned READY_ID  = 0;

endpackage

// File: rtl/hazard_reg_counter.sv
// hazard_reg_counter: one saturating-at-zero countdown slot.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear to zero (flush), beats load and dec
//   load       : load load_val, beats dec
//   load_val   : value to load
//   dec        : decrement by one when nonzero
//   cnt        : current count
module hazard_reg_counter
  import hazard_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Countdown register: reset > clear > load > decrement > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard for the ID stage.
// Each GPR has a counter loaded with (latency+1) when a writer issues; a
// reader stalls until the counter reaches its readiness threshold (<=1 for an
// EXE consumer fed by forwarding, ==0 for a branch resolved in ID). A separate
// counter tracks divider occupancy for HI/LO users.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   id_valid              : ID holds a real instruction
//   id_rs/id_rt(+_used)   : source indices and whether they are read
//   id_is_branch          : operands needed in ID
//   id_wreg/id_dst/id_lat : destination write, index, extra latency
//   id_is_div/id_uses_hilo: divider start / HI-LO access
//   mem_stall             : pipeline frozen by memory
//   flush                 : kill all in-flight instructions
//   stall                 : hold PC and IF/ID, bubble into EXE
//   issue                 : instruction leaves ID this cycle
//   div_busy              : divider occupied
//   stall_cycles          : saturating count of hazard-stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MAX_LAT    = 3,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_branch,
  input  logic              id_wreg,
  input  logic [REG_W-1:0]  id_dst,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              id_is_div,
  input  logic              id_uses_hilo,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic              div_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned REGS  = 2 ** REG_W;
  localparam int unsigned DIV_W = $clog2(DIV_CYCLES + 1);

  logic [LAT_W-1:0]  cnt_s [REGS];
  logic [DIV_W-1:0]  div_cnt_s;
  logic [LAT_W-1:0]  load_val_s;
  logic [LAT_W-1:0]  rs_cnt_s;
  logic [LAT_W-1:0]  rt_cnt_s;
  logic              issue_go_s;
  logic              rs_haz_s;
  logic              rt_haz_s;
  logic              hilo_haz_s;
  logic              stall_s;
  logic              issue_s;
  logic [PERF_W-1:0] perf_r;

  // A source is hazardous while its producer's countdown is above the
  // threshold for where the operand is consumed.
  function automatic logic src_hazard(input logic used, input logic nonzero,
                                      input logic [LAT_W-1:0] cnt,
                                      input logic is_branch);
    logic haz;
    haz = 1'b0;
    if (used && nonzero) begin
      if (is_branch) begin
        haz = (cnt > LAT_W'(READY_ID));
      end else begin
        haz = (cnt > LAT_W'(READY_EXE));
      end
    end else begin
      haz = 1'b0;
    end
    return haz;
  endfunction

  // A flush kills an instruction issuing in the same cycle, so it never
  // reaches the scoreboard.
  assign issue_go_s = issue_s && !flush;
  assign load_val_s = id_lat + LAT_W'(1);

  // Register 0 is hard-wired to zero and never produces a hazard.
  assign cnt_s[0] = {LAT_W{1'b0}};

  for (genvar r = 1; r < REGS; r++) begin : g_gpr
    hazard_reg_counter #(.W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .load     (issue_go_s && id_wreg && (id_dst == REG_W'(r))),
      .load_val (load_val_s),
      .dec      (!mem_stall),
      .cnt      (cnt_s[r])
    );
  end

  // The divider keeps running while memory freezes the pipeline.
  hazard_reg_counter #(.W(DIV_W)) u_div_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (issue_go_s && id_is_div),
    .load_val (DIV_W'(DIV_CYCLES)),
    .dec      (1'b1),
    .cnt      (div_cnt_s)
  );

  assign rs_cnt_s = cnt_s[id_rs];
  assign rt_cnt_s = cnt_s[id_rt];

  // Hazard detection and stall/issue decode from current scoreboard state.
  always_comb begin
    rs_haz_s   = src_hazard(id_rs_used, (id_rs != {REG_W{1'b0}}), rs_cnt_s, id_is_branch);
    rt_haz_s   = src_hazard(id_rt_used, (id_rt != {REG_W{1'b0}}), rt_cnt_s, id_is_branch);
    hilo_haz_s = (id_uses_hilo || id_is_div) && (div_cnt_s != {DIV_W{1'b0}});
    stall_s    = rst_n && id_valid && (rs_haz_s || rt_haz_s || hilo_haz_s);
    issue_s    = rst_n && id_valid && !stall_s && !mem_stall;
  end

  // Stall performance counter: counts hazard stalls only, saturates, and
  // survives a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_r <= {PERF_W{1'b0}};
    end else if (stall_s && !mem_stall && (perf_r != {PERF_W{1'b1}})) begin
      perf_r <= perf_r + PERF_W'(1);
    end else begin
      perf_r <= perf_r;
    end
  end

  assign stall        = stall_s;
  assign issue        = issue_s;
  assign div_busy     = (div_cnt_s != {DIV_W{1'b0}});
  assign stall_cycles = perf_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned LAT_W      = 3;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned PERF_W     = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_is_branch;
  logic              id_wreg;
  logic [REG_W-1:0]  id_dst;
  logic [LAT_W-1:0]  id_lat;
  logic              id_is_div;
  logic              id_uses_hilo;
  logic              mem_stall;
  logic              flush;
  logic              stall;
  logic              issue;
  logic              div_busy;
  logic [PERF_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_W(REG_W), .MAX_LAT(3), .LAT_W(LAT_W),
    .DIV_CYCLES(DIV_CYCLES), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_branch(id_is_branch), .id_wreg(id_wreg), .id_dst(id_dst), .id_lat(id_lat),
    .id_is_div(id_is_div), .id_uses_hilo(id_uses_hilo), .mem_stall(mem_stall),
    .flush(flush), .stall(stall), .issue(issue), .div_busy(div_busy),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [4:0]  rs;
    logic        rs_u;
    logic [4:0]  rt;
    logic        rt_u;
    logic        br;
    logic        wreg;
    logic [4:0]  dst;
    logic [2:0]  lat;
    logic        dv;
    logic        hilo;
    logic        ms;
    logic        fl;
    logic        e_stall;
    logic        e_issue;
    logic        e_busy;
    logic        chk_perf;
    logic [31:0] e_perf;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   idx      = 0;

  function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic rs_u,
                              input logic [4:0] rt, input logic rt_u, input logic br,
                              input logic wreg, input logic [4:0] dst, input logic [2:0] lat,
                              input logic e_stall, input logic e_issue);
    vec_t v;
    v.rst_n = 1'b1; v.valid = valid; v.rs = rs; v.rs_u = rs_u; v.rt = rt; v.rt_u = rt_u;
    v.br = br; v.wreg = wreg; v.dst = dst; v.lat = lat; v.dv = 1'b0; v.hilo = 1'b0;
    v.ms = 1'b0; v.fl = 1'b0; v.e_stall = e_stall; v.e_issue = e_issue; v.e_busy = 1'b0;
    v.chk_perf = 1'b0; v.e_perf = 32'd0;
    return v;
  endfunction

  // writer with no sources
  function automatic vec_t w(input logic [4:0] dst, input logic [2:0] lat,
                             input logic es, input logic ei);
    return mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, dst, lat, es, ei);
  endfunction

  // reader of rs only
  function automatic vec_t r(input logic [4:0] rs, input logic br,
                             input logic es, input logic ei);
    return mk(1'b1, rs, 1'b1, 5'd0, 1'b0, br, 1'b0, 5'd0, 3'd0, es, ei);
  endfunction

  function automatic vec_t nop();
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t wp(input vec_t v, input int p);
    vec_t o;
    o = v; o.chk_perf = 1'b1; o.e_perf = 32'(p);
    return o;
  endfunction

  function automatic vec_t divv(input logic busy);
    vec_t v;
    v = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
    v.dv = 1'b1; v.hilo = 1'b1; v.e_busy = busy;
    return v;
  endfunction

  function automatic vec_t mfhi(input logic es, input logic busy);
    vec_t v;
    v = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 3'd0, es, !es);
    v.hilo = 1'b1; v.e_busy = busy;
    return v;
  endfunction

  task automatic cmp(input string name, input int step_i, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %0d expected %0d", name, step_i, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; id_valid = v.valid; id_rs = v.rs; id_rs_used = v.rs_u;
    id_rt = v.rt; id_rt_used = v.rt_u; id_is_branch = v.br; id_wreg = v.wreg;
    id_dst = v.dst; id_lat = v.lat; id_is_div = v.dv; id_uses_hilo = v.hilo;
    mem_stall = v.ms; flush = v.fl;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare once settled.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    cmp("stall", idx, {31'd0, stall}, {31'd0, e.e_stall});
    cmp("issue", idx, {31'd0, issue}, {31'd0, e.e_issue});
    cmp("div_busy", idx, {31'd0, div_busy}, {31'd0, e.e_busy});
    if (e.chk_perf) begin
      cmp("stall_cycles", idx, 32'(stall_cycles), e.e_perf);
    end
    idx++;
  endtask

  initial begin
    vec_t v;
    drive(nop());
    rst_n = 1'b0;

    // reset
    v = nop(); v.rst_n = 1'b0; tbl.push_back(wp(v, 0));
    v = r(5'd8, 1'b0, 1'b0, 1'b0); v.rst_n = 1'b0; tbl.push_back(wp(v, 0));
    // load-use
    tbl.push_back(w(5'd8, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 3'd0, 1'b1, 1'b0));
    tbl.push_back(wp(mk(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 3'd0, 1'b0, 1'b1), 1));
    // branch after ALU
    tbl.push_back(mk(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 3'd0, 1'b0, 1'b1));
    tbl.push_back(r(5'd9, 1'b1, 1'b1, 1'b0));
    tbl.push_back(wp(r(5'd9, 1'b1, 1'b0, 1'b1), 2));
    // branch after load
    tbl.push_back(w(5'd9, 3'd1, 1'b0, 1'b1));
    tbl.push_back(r(5'd9, 1'b1, 1'b1, 1'b0));
    tbl.push_back(r(5'd9, 1'b1, 1'b1, 1'b0));
    tbl.push_back(wp(r(5'd9, 1'b1, 1'b0, 1'b1), 4));
    // ALU then non-branch reader
    tbl.push_back(w(5'd9, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1));
    // zero register and masking
    tbl.push_back(w(5'd0, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1));
    tbl.push_back(w(5'd12, 3'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'd0, 1'b0, 5'd12, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(wp(nop(), 5));
    // overwrite
    tbl.push_back(w(5'd6, 3'd1, 1'b0, 1'b1));
    tbl.push_back(w(5'd6, 3'd0, 1'b0, 1'b1));
    tbl.push_back(r(5'd6, 1'b0, 1'b0, 1'b1));
    // flush
    tbl.push_back(w(5'd5, 3'd1, 1'b0, 1'b1));
    v = nop(); v.fl = 1'b1; tbl.push_back(v);
    tbl.push_back(wp(r(5'd5, 1'b1, 1'b0, 1'b1), 5));
    v = w(5'd7, 3'd1, 1'b0, 1'b1); v.fl = 1'b1; tbl.push_back(v);
    tbl.push_back(r(5'd7, 1'b1, 1'b0, 1'b1));
    tbl.push_back(divv(1'b0));
    v = nop(); v.fl = 1'b1; v.e_busy = 1'b1; tbl.push_back(v);
    tbl.push_back(mfhi(1'b0, 1'b0));
    // memory freeze
    tbl.push_back(w(5'd4, 3'd1, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      v = r(5'd4, 1'b0, 1'b1, 1'b0); v.ms = 1'b1;
      tbl.push_back((i == 2) ? wp(v, 5) : v);
    end
    tbl.push_back(r(5'd4, 1'b0, 1'b1, 1'b0));
    tbl.push_back(wp(r(5'd4, 1'b0, 1'b0, 1'b1), 6));
    // reset mid-operation, with the pipeline frozen
    tbl.push_back(w(5'd13, 3'd1, 1'b0, 1'b1));
    v = nop(); v.rst_n = 1'b0; v.ms = 1'b1; tbl.push_back(wp(v, 6));
    tbl.push_back(wp(r(5'd13, 1'b1, 1'b0, 1'b1), 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // divider then HI/LO reader: DIV_CYCLES stall cycles
    step(divv(1'b0));
    for (int i = 0; i < DIV_CYCLES; i++) begin
      step(mfhi(1'b1, 1'b1));
    end
    step(wp(mfhi(1'b0, 1'b0), 32));

    // unrelated instruction while busy, then reader; counter reaches all-ones
    step(divv(1'b0));
    v = w(5'd3, 3'd0, 1'b0, 1'b1); v.e_busy = 1'b1; step(v);
    for (int i = 0; i < DIV_CYCLES - 1; i++) begin
      step(mfhi(1'b1, 1'b1));
    end
    step(wp(mfhi(1'b0, 1'b0), 63));

    // further stalls must not wrap the saturated counter
    step(divv(1'b0));
    for (int i = 0; i < DIV_CYCLES; i++) begin
      step(mfhi(1'b1, 1'b1));
    end
    step(wp(mfhi(1'b0, 1'b0), 63));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
